// File: rtl/rt_gray_cnt_chk_if.sv
// Control and status bundle for one Gray-coded pointer counter.
// The master drives the controls; the counter (slave) returns count, flags and checker status.
interface rt_gray_cnt_chk_if #(
    parameter int PARAM_BIT_NUM = 32
);
    logic                     rt_i_srst;
    logic                     rt_i_set;
    logic                     rt_i_ce;
    logic                     rt_i_inc_n;
    logic                     rt_i_sat;
    logic [PARAM_BIT_NUM-1:0] rt_i_ld_val;
    logic                     rt_i_err_clr;
    logic [PARAM_BIT_NUM-1:0] rt_o_bin_cnt;
    logic [PARAM_BIT_NUM-1:0] rt_o_gray_cnt;
    logic                     rt_o_eqnz;
    logic                     rt_o_tc;
    logic                     rt_o_err;

    modport master (
        output rt_i_srst, rt_i_set, rt_i_ce, rt_i_inc_n, rt_i_sat, rt_i_ld_val, rt_i_err_clr,
        input  rt_o_bin_cnt, rt_o_gray_cnt, rt_o_eqnz, rt_o_tc, rt_o_err
    );

    modport slave (
        input  rt_i_srst, rt_i_set, rt_i_ce, rt_i_inc_n, rt_i_sat, rt_i_ld_val, rt_i_err_clr,
        output rt_o_bin_cnt, rt_o_gray_cnt, rt_o_eqnz, rt_o_tc, rt_o_err
    );
endinterface

// File: rtl/rt_gray_cnt_chk.sv
// Up/down binary counter with a coherent registered Gray image, wrap/saturate mode,
// terminal-count pulse and a sticky self-checker guarding the Gray register.
module rt_gray_cnt_chk #(
    parameter int                       PARAM_BIT_NUM = 32,
    parameter logic [PARAM_BIT_NUM-1:0] PARAM_RST_VAL = '0
) (
    input  logic               rt_i_clk,
    input  logic               rt_i_rst,
    rt_gray_cnt_chk_if.slave   bus
);
    localparam int                 W        = PARAM_BIT_NUM;
    localparam logic [W-1:0]       ALL_ONES = '1;
    localparam logic [W-1:0]       ZERO     = '0;
    localparam logic [W-1:0]       ONE      = W'(1);
    localparam logic [W-1:0]       RST_GRAY = PARAM_RST_VAL ^ (PARAM_RST_VAL >> 1);

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;
    logic [W-1:0] gray_prev_q, gray_prev_d;
    logic         tc_q, tc_d;
    logic         step_q, step_d;
    logic         err_q, err_d;

    logic [W-1:0] gray_dec;
    logic [W-1:0] gray_diff;
    logic         diff_onehot;
    logic         roundtrip_bad;
    logic         step_bad;

    // Next count: srst > set > ce. Only a real +/-1 move (including a wrap) is a step.
    always_comb begin
        bin_d  = bin_q;
        tc_d   = 1'b0;
        step_d = 1'b0;
        if (bus.rt_i_srst) begin
            bin_d = PARAM_RST_VAL;
        end else if (bus.rt_i_set) begin
            bin_d = bus.rt_i_ld_val;
        end else if (bus.rt_i_ce) begin
            if (!bus.rt_i_inc_n) begin
                if (bin_q == ALL_ONES) begin
                    tc_d = 1'b1;
                    if (!bus.rt_i_sat) begin
                        bin_d  = ZERO;
                        step_d = 1'b1;
                    end
                end else begin
                    bin_d  = bin_q + ONE;
                    step_d = 1'b1;
                end
            end else begin
                if (bin_q == ZERO) begin
                    tc_d = 1'b1;
                    if (!bus.rt_i_sat) begin
                        bin_d  = ALL_ONES;
                        step_d = 1'b1;
                    end
                end else begin
                    bin_d  = bin_q - ONE;
                    step_d = 1'b1;
                end
            end
        end
        gray_d      = bin_d ^ (bin_d >> 1);
        gray_prev_d = step_d ? gray_q : gray_prev_q;
    end

    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
    for (genvar gi = 0; gi < W; gi++) begin : g_gray_dec
        assign gray_dec[gi] = ^gray_q[W-1:gi];
    end

    assign gray_diff     = gray_q ^ gray_prev_q;
    assign diff_onehot   = (gray_diff != ZERO) && ((gray_diff & (gray_diff - ONE)) == ZERO);
    assign roundtrip_bad = (gray_dec != bin_q);
    assign step_bad      = step_q && !diff_onehot;

    // A fresh failure overrides a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (roundtrip_bad || step_bad) begin
            err_d = 1'b1;
        end else if (bus.rt_i_err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge rt_i_clk or posedge rt_i_rst) begin
        if (rt_i_rst) begin
            bin_q       <= PARAM_RST_VAL;
            gray_q      <= RST_GRAY;
            gray_prev_q <= ZERO;
            tc_q        <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            gray_q      <= gray_d;
            gray_prev_q <= gray_prev_d;
            tc_q        <= tc_d;
            step_q      <= step_d;
            err_q       <= err_d;
        end
    end

    assign bus.rt_o_bin_cnt  = bin_q;
    assign bus.rt_o_gray_cnt = gray_q;
    assign bus.rt_o_eqnz     = (bin_q != ZERO);
    assign bus.rt_o_tc       = tc_q;
    assign bus.rt_o_err      = err_q;
endmodule

// File: tb/tb_rt_gray_cnt_chk.sv
// Bench for rt_gray_cnt_chk: 4-bit and 32-bit instances against an arithmetic reference model,
// directed scenarios plus randomized traffic, and a forced Gray fault to exercise the checker.
module tb_rt_gray_cnt_chk;
    logic clk;
    logic rst;

    int n_vec;
    int n_bad;

    longint unsigned m4_bin;
    bit              m4_tc;
    longint unsigned m32_bin;
    bit              m32_tc;

    rt_gray_cnt_chk_if #(.PARAM_BIT_NUM(4))  if4 ();
    rt_gray_cnt_chk_if #(.PARAM_BIT_NUM(32)) if32 ();

    rt_gray_cnt_chk #(.PARAM_BIT_NUM(4)) dut4 (
        .rt_i_clk (clk),
        .rt_i_rst (rst),
        .bus      (if4)
    );

    rt_gray_cnt_chk #(.PARAM_BIT_NUM(32)) dut32 (
        .rt_i_clk (clk),
        .rt_i_rst (rst),
        .bus      (if32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed step, out-of-range means terminal count; wrap via modulo or hold.
    function automatic void ref_next(input int w, input longint unsigned cur,
                                     input bit srst, input bit set, input bit ce,
                                     input bit inc_n, input bit sat, input longint unsigned ld,
                                     output longint unsigned nxt, output bit tc);
        longint modv;
        longint raw;
        modv = longint'(64'd1 << w);
        nxt  = cur;
        tc   = 1'b0;
        if (srst) begin
            nxt = 0;
        end else if (set) begin
            nxt = ld % longint'(modv);
        end else if (ce) begin
            raw = longint'(cur) + (inc_n ? -1 : 1);
            if (raw < 0 || raw >= modv) begin
                tc  = 1'b1;
                nxt = sat ? cur : longint'((raw + modv) % modv);
            end else begin
                nxt = raw;
            end
        end
    endfunction

    function automatic longint unsigned gray_of(input longint unsigned x);
        return x ^ (x >> 1);
    endfunction

    task automatic drive4(input bit srst, input bit set, input bit ce, input bit inc_n,
                          input bit sat, input logic [3:0] ld, input bit clr);
        if4.rt_i_srst    = srst;
        if4.rt_i_set     = set;
        if4.rt_i_ce      = ce;
        if4.rt_i_inc_n   = inc_n;
        if4.rt_i_sat     = sat;
        if4.rt_i_ld_val  = ld;
        if4.rt_i_err_clr = clr;
        @(posedge clk);
        #1;
        ref_next(4, m4_bin, srst, set, ce, inc_n, sat, longint'(ld), m4_bin, m4_tc);
    endtask

    task automatic drive32(input bit srst, input bit set, input bit ce, input bit inc_n,
                           input bit sat, input logic [31:0] ld, input bit clr);
        if32.rt_i_srst    = srst;
        if32.rt_i_set     = set;
        if32.rt_i_ce      = ce;
        if32.rt_i_inc_n   = inc_n;
        if32.rt_i_sat     = sat;
        if32.rt_i_ld_val  = ld;
        if32.rt_i_err_clr = clr;
        @(posedge clk);
        #1;
        ref_next(32, m32_bin, srst, set, ce, inc_n, sat, longint'(ld), m32_bin, m32_tc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive4(0, 0, 0, 0, 0, 4'h0, 0);
        drive32(0, 0, 0, 0, 0, 32'h0, 0);
        m4_bin = 0; m4_tc = 0; m32_bin = 0; m32_tc = 0;
        n_vec++;
        if (if4.rt_o_bin_cnt !== 4'h0 || if4.rt_o_gray_cnt !== 4'h0 || if4.rt_o_tc !== 1'b0 ||
            if4.rt_o_err !== 1'b0 || if4.rt_o_eqnz !== 1'b0) begin
            n_bad++;
            $display("FAIL reset4: got bin=%h gray=%h tc=%b err=%b eqnz=%b want all 0",
                     if4.rt_o_bin_cnt, if4.rt_o_gray_cnt, if4.rt_o_tc, if4.rt_o_err, if4.rt_o_eqnz);
        end
        n_vec++;
        if (if32.rt_o_bin_cnt !== 32'h0 || if32.rt_o_gray_cnt !== 32'h0 || if32.rt_o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset32: got bin=%h gray=%h err=%b want 0", if32.rt_o_bin_cnt,
                     if32.rt_o_gray_cnt, if32.rt_o_err);
        end
        rst = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_wrap_count();
        int tc_seen;
        tc_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive4(0, 0, 1, 0, 0, 4'h0, 0);
            tc_seen += int'(if4.rt_o_tc);
            n_vec++;
            if (if4.rt_o_bin_cnt !== 4'((i + 1) % 16) || if4.rt_o_bin_cnt !== 4'(m4_bin)) begin
                n_bad++;
                $display("FAIL wrap_bin cyc%0d: got %h want %h", i, if4.rt_o_bin_cnt, 4'((i + 1) % 16));
            end
            n_vec++;
            if (if4.rt_o_gray_cnt !== 4'(gray_of(m4_bin))) begin
                n_bad++;
                $display("FAIL wrap_gray cyc%0d: got %h want %h", i, if4.rt_o_gray_cnt, 4'(gray_of(m4_bin)));
            end
            n_vec++;
            if (if4.rt_o_tc !== m4_tc || if4.rt_o_eqnz !== (m4_bin != 0) || if4.rt_o_err !== 1'b0) begin
                n_bad++;
                $display("FAIL wrap_flags cyc%0d: got tc=%b eqnz=%b err=%b want tc=%b eqnz=%b err=0",
                         i, if4.rt_o_tc, if4.rt_o_eqnz, if4.rt_o_err, m4_tc, (m4_bin != 0));
            end
            $display("wrap cyc%0d: bin=%h gray=%h tc=%b", i, if4.rt_o_bin_cnt, if4.rt_o_gray_cnt, if4.rt_o_tc);
        end
        n_vec++;
        if (tc_seen != 1) begin
            n_bad++;
            $display("FAIL wrap_tc_count: got %0d want 1", tc_seen);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_bin [5];
        bit         exp_tc  [5];
        exp_bin = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF};
        exp_tc  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        drive4(0, 1, 0, 0, 1, 4'hE, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) drive4(0, 1, 0, 1, 0, 4'h1, 0);
            if (i < 3) drive4(0, 0, 1, 0, 1, 4'h0, 0);
            else       drive4(0, 0, 1, 1, 0, 4'h0, 0);
            n_vec++;
            if (if4.rt_o_bin_cnt !== exp_bin[i] || if4.rt_o_tc !== exp_tc[i] || if4.rt_o_err !== 1'b0) begin
                n_bad++;
                $display("FAIL sat step%0d: got bin=%h tc=%b err=%b want bin=%h tc=%b err=0",
                         i, if4.rt_o_bin_cnt, if4.rt_o_tc, if4.rt_o_err, exp_bin[i], exp_tc[i]);
            end
            n_vec++;
            if (if4.rt_o_gray_cnt !== 4'(gray_of(longint'(exp_bin[i])))) begin
                n_bad++;
                $display("FAIL sat_gray step%0d: got %h want %h", i, if4.rt_o_gray_cnt,
                         4'(gray_of(longint'(exp_bin[i]))));
            end
            $display("sat step%0d: bin=%h gray=%h tc=%b", i, if4.rt_o_bin_cnt, if4.rt_o_gray_cnt, if4.rt_o_tc);
        end
    endtask

    task automatic test_priority();
        drive4(1, 1, 1, 0, 0, 4'h9, 0);
        n_vec++;
        if (if4.rt_o_bin_cnt !== 4'h0 || if4.rt_o_tc !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_srst: got bin=%h tc=%b want bin=0 tc=0", if4.rt_o_bin_cnt, if4.rt_o_tc);
        end
        drive4(0, 1, 1, 0, 0, 4'h9, 0);
        n_vec++;
        if (if4.rt_o_bin_cnt !== 4'h9 || if4.rt_o_gray_cnt !== 4'hD || if4.rt_o_bin_cnt !== 4'(m4_bin)) begin
            n_bad++;
            $display("FAIL prio_set: got bin=%h gray=%h want bin=9 gray=d", if4.rt_o_bin_cnt, if4.rt_o_gray_cnt);
        end
        $display("priority: bin=%h gray=%h", if4.rt_o_bin_cnt, if4.rt_o_gray_cnt);
    endtask

    task automatic test_async_reset();
        drive4(0, 1, 0, 0, 0, 4'h5, 0);
        drive4(0, 0, 1, 0, 0, 4'h0, 0);
        drive4(0, 0, 1, 0, 0, 4'h0, 0);
        n_vec++;
        if (if4.rt_o_bin_cnt !== 4'h7) begin
            n_bad++;
            $display("FAIL arst_pre: got bin=%h want 7", if4.rt_o_bin_cnt);
        end
        #2 rst = 1'b1;
        #1;
        m4_bin = 0; m4_tc = 0; m32_bin = 0; m32_tc = 0;
        n_vec++;
        if (if4.rt_o_bin_cnt !== 4'h0 || if4.rt_o_gray_cnt !== 4'h0 || if4.rt_o_tc !== 1'b0 ||
            if4.rt_o_eqnz !== 1'b0 || if4.rt_o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_now: got bin=%h gray=%h tc=%b eqnz=%b err=%b want all 0",
                     if4.rt_o_bin_cnt, if4.rt_o_gray_cnt, if4.rt_o_tc, if4.rt_o_eqnz, if4.rt_o_err);
        end
        if4.rt_i_ce = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            drive4(0, 0, 1, 0, 0, 4'h0, 0);
            n_vec++;
            if (if4.rt_o_bin_cnt !== 4'(m4_bin) || if4.rt_o_err !== 1'b0) begin
                n_bad++;
                $display("FAIL arst_after cyc%0d: got bin=%h err=%b want bin=%h err=0",
                         i, if4.rt_o_bin_cnt, if4.rt_o_err, 4'(m4_bin));
            end
        end
        $display("async reset: resumed bin=%h", if4.rt_o_bin_cnt);
    endtask

    task automatic test_force_err();
        drive4(0, 1, 0, 0, 0, 4'h2, 0);
        drive4(0, 0, 0, 0, 0, 4'h0, 0);
        force dut4.gray_q = 4'b0101;
        drive4(0, 0, 0, 0, 0, 4'h0, 0);
        release dut4.gray_q;
        n_vec++;
        if (if4.rt_o_err !== 1'b1) begin
            n_bad++;
            $display("FAIL force_err_rise: got %b want 1", if4.rt_o_err);
        end
        drive4(0, 0, 0, 0, 0, 4'h0, 0);
        drive4(0, 0, 0, 0, 0, 4'h0, 0);
        n_vec++;
        if (if4.rt_o_err !== 1'b1 || if4.rt_o_gray_cnt !== 4'h3 || if4.rt_o_bin_cnt !== 4'h2) begin
            n_bad++;
            $display("FAIL force_err_sticky: got err=%b gray=%h bin=%h want err=1 gray=3 bin=2",
                     if4.rt_o_err, if4.rt_o_gray_cnt, if4.rt_o_bin_cnt);
        end
        drive4(0, 0, 0, 0, 0, 4'h0, 1);
        drive4(0, 0, 0, 0, 0, 4'h0, 0);
        n_vec++;
        if (if4.rt_o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL force_err_clr: got %b want 0", if4.rt_o_err);
        end
        force dut4.gray_q = 4'b0101;
        drive4(0, 0, 0, 0, 0, 4'h0, 1);
        release dut4.gray_q;
        n_vec++;
        if (if4.rt_o_err !== 1'b1) begin
            n_bad++;
            $display("FAIL force_err_wins_clr: got %b want 1", if4.rt_o_err);
        end
        drive4(0, 0, 0, 0, 0, 4'h0, 0);
        drive4(0, 0, 0, 0, 0, 4'h0, 1);
        drive4(0, 0, 0, 0, 0, 4'h0, 0);
        n_vec++;
        if (if4.rt_o_err !== 1'b0 || if4.rt_o_gray_cnt !== 4'h3) begin
            n_bad++;
            $display("FAIL force_err_final: got err=%b gray=%h want err=0 gray=3", if4.rt_o_err, if4.rt_o_gray_cnt);
        end
        $display("force: checker raised and cleared");
    endtask

    task automatic test_random();
        bit b_srst, b_set, b_ce, b_inc_n, b_sat, b_clr;
        logic [3:0] ld;
        for (int i = 0; i < 300; i++) begin
            b_srst  = ($urandom_range(0, 31) == 0);
            b_set   = ($urandom_range(0, 9) == 0);
            b_ce    = ($urandom_range(0, 3) != 0);
            b_inc_n = $urandom_range(0, 1) == 1;
            b_sat   = ($urandom_range(0, 3) == 0);
            b_clr   = ($urandom_range(0, 7) == 0);
            ld      = 4'($urandom);
            drive4(b_srst, b_set, b_ce, b_inc_n, b_sat, ld, b_clr);
            n_vec++;
            if (if4.rt_o_bin_cnt !== 4'(m4_bin) || if4.rt_o_gray_cnt !== 4'(gray_of(m4_bin)) ||
                if4.rt_o_tc !== m4_tc || if4.rt_o_eqnz !== (m4_bin != 0) || if4.rt_o_err !== 1'b0) begin
                n_bad++;
                $display("FAIL rand cyc%0d: got bin=%h gray=%h tc=%b eqnz=%b err=%b want bin=%h gray=%h tc=%b eqnz=%b err=0",
                         i, if4.rt_o_bin_cnt, if4.rt_o_gray_cnt, if4.rt_o_tc, if4.rt_o_eqnz, if4.rt_o_err,
                         4'(m4_bin), 4'(gray_of(m4_bin)), m4_tc, (m4_bin != 0));
            end
            $display("rand cyc%0d: bin=%h tc=%b", i, if4.rt_o_bin_cnt, if4.rt_o_tc);
        end
    endtask

    task automatic test_wide();
        int tc_seen;
        tc_seen = 0;
        drive32(0, 1, 0, 0, 0, 32'hFFFF_FFFE, 0);
        for (int i = 0; i < 4; i++) begin
            drive32(0, 0, 1, 0, 0, 32'h0, 0);
            tc_seen += int'(if32.rt_o_tc);
            n_vec++;
            if (if32.rt_o_bin_cnt !== 32'(m32_bin) || if32.rt_o_gray_cnt !== 32'(gray_of(m32_bin)) ||
                if32.rt_o_tc !== m32_tc || if32.rt_o_err !== 1'b0) begin
                n_bad++;
                $display("FAIL wide cyc%0d: got bin=%h gray=%h tc=%b err=%b want bin=%h gray=%h tc=%b err=0",
                         i, if32.rt_o_bin_cnt, if32.rt_o_gray_cnt, if32.rt_o_tc, if32.rt_o_err,
                         32'(m32_bin), 32'(gray_of(m32_bin)), m32_tc);
            end
            if (i == 0) begin
                n_vec++;
                if (if32.rt_o_bin_cnt !== 32'hFFFF_FFFF || if32.rt_o_gray_cnt !== 32'h8000_0000) begin
                    n_bad++;
                    $display("FAIL wide_top: got bin=%h gray=%h want ffffffff/80000000",
                             if32.rt_o_bin_cnt, if32.rt_o_gray_cnt);
                end
            end
            $display("wide cyc%0d: bin=%h gray=%h tc=%b", i, if32.rt_o_bin_cnt, if32.rt_o_gray_cnt, if32.rt_o_tc);
        end
        n_vec++;
        if (tc_seen != 1 || if32.rt_o_bin_cnt !== 32'h2) begin
            n_bad++;
            $display("FAIL wide_end: got tc_count=%0d bin=%h want 1 / 2", tc_seen, if32.rt_o_bin_cnt);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        test_reset();
        test_wrap_count();
        test_saturate();
        test_priority();
        test_async_reset();
        test_force_err();
        test_random();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
